// File: rtl/pmp_csr_file_pkg.sv
// Shared definitions for the PMP CSR file: CSR addresses, cfg field layout,
// FSM states, and the Smepmp rule for rejected M-mode-executable codes.
package pmp_pkg;

   localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
   localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
   localparam logic [11:0] CSR_MSECCFG  = 12'h747;
   localparam logic [11:0] CSR_MSECCFGH = 12'h757;

   typedef enum logic [1:0] {
      A_OFF   = 2'd0,
      A_TOR   = 2'd1,
      A_NA4   = 2'd2,
      A_NAPOT = 2'd3
   } pmp_a_e;

   typedef struct packed {
      logic   l;
      pmp_a_e a;
      logic   x;
      logic   w;
      logic   r;
   } pmp_cfg_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESP  = 2'd1,
      ST_FLUSH = 2'd2
   } csr_state_e;

   // With MML set, {L,R,W,X} codes 9, 10, 11 and 13 would create an
   // M-mode-executable region and are refused.
   function automatic logic mml_rejected(pmp_cfg_t c);
      logic [3:0] code;
      code = {c.l, c.r, c.w, c.x};
      return (code == 4'd9) || (code == 4'd10) || (code == 4'd11) || (code == 4'd13);
   endfunction

   // Bits [6:5] of a cfg byte are not stored and read back as 0.
   function automatic logic [7:0] cfg_to_byte(pmp_cfg_t c);
      return {c.l, 2'b00, c.a, c.x, c.w, c.r};
   endfunction

   function automatic pmp_cfg_t byte_to_cfg(logic [7:0] b);
      pmp_cfg_t c;
      c.l = b[7];
      c.a = pmp_a_e'(b[4:3]);
      c.x = b[2];
      c.w = b[1];
      c.r = b[0];
      return c;
   endfunction

endpackage

// File: rtl/pmp_csr_file_if.sv
// CSR request/response bus plus the flush handshake toward fetch and LSU.
interface pmp_csr_file_if;
   logic        csr_valid_i;
   logic        csr_ready_o;
   logic        csr_write_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic        csr_rvalid_o;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;
   logic        pmp_flush_o;
   logic        pmp_flush_ack_i;

   modport master (
      output csr_valid_i, csr_write_i, csr_addr_i, csr_wdata_i, pmp_flush_ack_i,
      input  csr_ready_o, csr_rvalid_o, csr_rdata_o, csr_illegal_o, pmp_flush_o
   );

   modport slave (
      input  csr_valid_i, csr_write_i, csr_addr_i, csr_wdata_i, pmp_flush_ack_i,
      output csr_ready_o, csr_rvalid_o, csr_rdata_o, csr_illegal_o, pmp_flush_o
   );
endinterface

// File: rtl/pmp_csr_file_cfg_entry.sv
// One pmpcfg field: stores the entry's rule bits and filters writes through
// the lock, WARL and Smepmp rejection rules.
module pmp_cfg_entry
   import pmp_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rlb,
   input  logic       mml,
   input  logic       wr_en,
   input  logic [7:0] wdata,
   output pmp_cfg_t   cfg,
   output pmp_cfg_t   cfg_next,
   output logic       changed
);

   pmp_cfg_t wr_cfg;
   logic     wr_ok;

   // Legalise the incoming byte and decide whether this entry takes it.
   always_comb begin
      wr_cfg = byte_to_cfg(wdata);
      if (!mml && !wr_cfg.r && wr_cfg.w) begin
         wr_cfg.w = 1'b0;
      end
      wr_ok = wr_en
            && !(cfg.l && !rlb)
            && !(mml && !rlb && mml_rejected(wr_cfg));
      cfg_next = wr_ok ? wr_cfg : cfg;
      changed  = (cfg_next != cfg);
   end

   // Field storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg <= '0;
      end else begin
         cfg <= cfg_next;
      end
   end

endmodule

// File: rtl/pmp_csr_file.sv
// PMP/Smepmp CSR storage: address decode, pmpaddr array, mseccfg and the
// request/response/flush sequencer.
//
// state    | meaning
// ST_IDLE  | ready; a valid request is committed on acceptance
// ST_RESP  | one-cycle response strobe with rdata/illegal
// ST_FLUSH | state changed; hold pmp_flush_o until acknowledged
module pmp_csr_file
   import pmp_pkg::*;
#(
   parameter bit          ENABLE_SMEPMP = 1'b1,
   parameter int unsigned PMP_ENTRIES   = 8
) (
   input  logic                        cpu_clock_i,
   input  logic                        cpu_reset_n_i,
   pmp_csr_file_if.slave               bus,
   output logic [PMP_ENTRIES-1:0]      cfg_lock_o,
   output logic [PMP_ENTRIES-1:0]      cfg_r_o,
   output logic [PMP_ENTRIES-1:0]      cfg_w_o,
   output logic [PMP_ENTRIES-1:0]      cfg_x_o,
   output logic [2*PMP_ENTRIES-1:0]    cfg_a_o,
   output logic [32*PMP_ENTRIES-1:0]   addr_o,
   output logic                        mml_o,
   output logic                        mmwp_o
);

   localparam int unsigned NMAX = 16;

   csr_state_e  state;
   logic        ready_q, rvalid_q, illegal_q, flush_q, pend_q;
   logic [31:0] rdata_q;

   logic        accept, wr;
   logic        is_cfg, is_addr, is_msec, is_msech, illegal_nx;
   logic [1:0]  cfg_sel;
   logic [3:0]  addr_sel, cfg_base;
   logic [31:0] rdata_nx;
   logic        change;

   pmp_cfg_t    cfg_q  [NMAX+1];
   pmp_cfg_t    cfg_nx [NMAX];
   logic [NMAX-1:0] cfg_chg;
   logic [31:0] addr_q  [NMAX];
   logic [31:0] addr_nx [NMAX];
   logic [NMAX-1:0] addr_chg;

   logic mml_q, mmwp_q, rlb_q, mml_nx, mmwp_nx, rlb_nx, any_locked;

   // Address decode and acceptance.
   always_comb begin
      accept     = (state == ST_IDLE) && bus.csr_valid_i;
      wr         = accept && bus.csr_write_i;
      is_cfg     = (bus.csr_addr_i[11:2] == CSR_PMPCFG0[11:2]);
      is_addr    = (bus.csr_addr_i[11:4] == CSR_PMPADDR0[11:4]);
      is_msec    = (bus.csr_addr_i == CSR_MSECCFG);
      is_msech   = (bus.csr_addr_i == CSR_MSECCFGH);
      illegal_nx = !(is_cfg || is_addr || is_msec || is_msech);
      cfg_sel    = bus.csr_addr_i[1:0];
      addr_sel   = bus.csr_addr_i[3:0];
      cfg_base   = {cfg_sel, 2'b00};
   end

   // Per-entry cfg and pmpaddr; unimplemented slots read as zero.
   for (genvar i = 0; i <= NMAX; i++) begin : g_ent
      if (i < PMP_ENTRIES) begin : g_on
         logic        addr_wr;
         logic [31:0] addr_r;

         pmp_cfg_entry u_cfg (
            .clk      (cpu_clock_i),
            .rst_n    (cpu_reset_n_i),
            .rlb      (rlb_q),
            .mml      (mml_q),
            .wr_en    (wr && is_cfg && (cfg_sel == 2'(i / 4))),
            .wdata    (bus.csr_wdata_i[8*(i%4) +: 8]),
            .cfg      (cfg_q[i]),
            .cfg_next (cfg_nx[i]),
            .changed  (cfg_chg[i])
         );

         // A TOR region above this entry uses pmpaddr[i] as its base, so
         // locking it also freezes this address.
         assign addr_wr = wr && is_addr && (addr_sel == 4'(i))
                        && (rlb_q || !(cfg_q[i].l
                                       || (cfg_q[i+1].l && cfg_q[i+1].a == A_TOR)));
         assign addr_nx[i]  = addr_wr ? bus.csr_wdata_i : addr_r;
         assign addr_chg[i] = (addr_nx[i] != addr_r);
         assign addr_q[i]   = addr_r;

         // pmpaddr storage.
         always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
            if (!cpu_reset_n_i) begin
               addr_r <= '0;
            end else begin
               addr_r <= addr_nx[i];
            end
         end

         assign cfg_lock_o[i]       = cfg_q[i].l;
         assign cfg_r_o[i]          = cfg_q[i].r;
         assign cfg_w_o[i]          = cfg_q[i].w;
         assign cfg_x_o[i]          = cfg_q[i].x;
         assign cfg_a_o[2*i +: 2]   = cfg_q[i].a;
         assign addr_o[32*i +: 32]  = addr_r;
      end else begin : g_off
         assign cfg_q[i] = '0;
         if (i < NMAX) begin : g_pad
            assign cfg_nx[i]   = '0;
            assign cfg_chg[i]  = 1'b0;
            assign addr_q[i]   = '0;
            assign addr_nx[i]  = '0;
            assign addr_chg[i] = 1'b0;
         end
      end
   end

   assign any_locked = |cfg_lock_o;

   // mseccfg next value: MML/MMWP sticky-set, RLB frozen once cleared under lock.
   always_comb begin
      mml_nx  = mml_q;
      mmwp_nx = mmwp_q;
      rlb_nx  = rlb_q;
      if (ENABLE_SMEPMP && wr && is_msec) begin
         mml_nx  = mml_q  | bus.csr_wdata_i[0];
         mmwp_nx = mmwp_q | bus.csr_wdata_i[1];
         if (!any_locked || rlb_q) begin
            rlb_nx = bus.csr_wdata_i[2];
         end
      end
   end

   // mseccfg storage.
   always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
      if (!cpu_reset_n_i) begin
         mml_q  <= 1'b0;
         mmwp_q <= 1'b0;
         rlb_q  <= 1'b0;
      end else begin
         mml_q  <= mml_nx;
         mmwp_q <= mmwp_nx;
         rlb_q  <= rlb_nx;
      end
   end

   assign mml_o  = mml_q;
   assign mmwp_o = mmwp_q;

   // Post-commit read value and whether any stored bit moved.
   always_comb begin
      rdata_nx = '0;
      if (is_cfg) begin
         rdata_nx = {cfg_to_byte(cfg_nx[cfg_base + 4'd3]), cfg_to_byte(cfg_nx[cfg_base + 4'd2]),
                     cfg_to_byte(cfg_nx[cfg_base + 4'd1]), cfg_to_byte(cfg_nx[cfg_base])};
      end else if (is_addr) begin
         rdata_nx = addr_nx[addr_sel];
      end else if (is_msec) begin
         rdata_nx = {29'd0, rlb_nx, mmwp_nx, mml_nx};
      end
      change = (|cfg_chg) || (|addr_chg)
             || ({mml_nx, mmwp_nx, rlb_nx} != {mml_q, mmwp_q, rlb_q});
   end

   // Request sequencer with registered handshake outputs.
   always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
      if (!cpu_reset_n_i) begin
         state     <= ST_IDLE;
         ready_q   <= 1'b1;
         rvalid_q  <= 1'b0;
         illegal_q <= 1'b0;
         rdata_q   <= '0;
         flush_q   <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         rvalid_q  <= 1'b0;
         illegal_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state     <= ST_RESP;
                  ready_q   <= 1'b0;
                  rvalid_q  <= 1'b1;
                  illegal_q <= illegal_nx;
                  rdata_q   <= rdata_nx;
                  pend_q    <= change;
               end
            end
            ST_RESP: begin
               if (pend_q) begin
                  state   <= ST_FLUSH;
                  flush_q <= 1'b1;
               end else begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (bus.pmp_flush_ack_i) begin
                  state   <= ST_IDLE;
                  flush_q <= 1'b0;
                  ready_q <= 1'b1;
                  pend_q  <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.csr_ready_o   = ready_q;
   assign bus.csr_rvalid_o  = rvalid_q;
   assign bus.csr_rdata_o   = rdata_q;
   assign bus.csr_illegal_o = illegal_q;
   assign bus.pmp_flush_o   = flush_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed bench for pmp_csr_file: lock/WARL/Smepmp rules, flush handshake,
// address map and reset behaviour.
module tb_pmp_csr_file;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pmp_csr_file_if bus ();

   logic [7:0]   cfg_lock, cfg_r, cfg_w, cfg_x;
   logic [15:0]  cfg_a;
   logic [255:0] addr;
   logic         mml, mmwp;

   int checks = 0;
   int errors = 0;

   pmp_csr_file #(.ENABLE_SMEPMP(1'b1), .PMP_ENTRIES(8)) dut (
      .cpu_clock_i   (clk),
      .cpu_reset_n_i (rst_n),
      .bus           (bus),
      .cfg_lock_o    (cfg_lock),
      .cfg_r_o       (cfg_r),
      .cfg_w_o       (cfg_w),
      .cfg_x_o       (cfg_x),
      .cfg_a_o       (cfg_a),
      .addr_o        (addr),
      .mml_o         (mml),
      .mmwp_o        (mmwp)
   );

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One transaction; returns observations, the callers judge them.
   task automatic do_req(input logic w, input logic [11:0] a, input logic [31:0] d,
                         input int ack_delay,
                         output logic rv, output logic [31:0] rd, output logic ill,
                         output logic fl, output logic hold_ok, output logic rdy_end);
      int n;
      n = 0;
      hold_ok = 1'b1;
      @(negedge clk);
      while (!bus.csr_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.csr_valid_i = 1'b1;
      bus.csr_write_i = w;
      bus.csr_addr_i  = a;
      bus.csr_wdata_i = d;
      @(negedge clk);
      rv  = bus.csr_rvalid_o;
      rd  = bus.csr_rdata_o;
      ill = bus.csr_illegal_o;
      bus.csr_valid_i = 1'b0;
      @(negedge clk);
      fl = bus.pmp_flush_o;
      if (fl) begin
         for (int k = 0; k < ack_delay; k++) begin
            hold_ok = hold_ok & bus.pmp_flush_o & !bus.csr_ready_o;
            @(negedge clk);
         end
         hold_ok = hold_ok & bus.pmp_flush_o & !bus.csr_ready_o;
         bus.pmp_flush_ack_i = 1'b1;
         @(negedge clk);
         bus.pmp_flush_ack_i = 1'b0;
      end
      rdy_end = bus.csr_ready_o;
   endtask

   task automatic test_reset();
      logic rv, ill, fl, ho, re;
      logic [31:0] rd;
      apply_reset();
      checks++;
      if ({bus.csr_ready_o, bus.csr_rvalid_o, bus.pmp_flush_o, bus.csr_illegal_o, bus.csr_rdata_o} !== {4'b1000, 32'h0}) begin
         errors++;
         $display("FAIL reset_bus: got rdy/rv/fl/ill/rd=%b%b%b%b/%h want 1000/00000000",
                  bus.csr_ready_o, bus.csr_rvalid_o, bus.pmp_flush_o, bus.csr_illegal_o, bus.csr_rdata_o);
      end
      checks++;
      if ({cfg_lock, cfg_r, cfg_w, cfg_x, cfg_a, addr, mml, mmwp} !== '0) begin
         errors++;
         $display("FAIL reset_rules: got lock=%h a=%h addr0=%h mml=%b want all 0", cfg_lock, cfg_a, addr[31:0], mml);
      end
      do_req(1'b0, 12'h3A0, 32'h0, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, ill, fl, re, rd} !== {4'b1001, 32'h0}) begin
         errors++;
         $display("FAIL read_cfg0: got rv/ill/fl/rdy=%b%b%b%b rd=%h want 1001 rd=00000000", rv, ill, fl, re, rd);
      end
   endtask

   task automatic test_warl();
      logic rv, ill, fl, ho, re;
      logic [31:0] rd;
      do_req(1'b1, 12'h3A0, 32'h0000_0002, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, ill, fl, rd, cfg_w[0]} !== {3'b100, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL warl_w_only: got rv/ill/fl=%b%b%b rd=%h w0=%b want 100 rd=00000000 w0=0", rv, ill, fl, rd, cfg_w[0]);
      end
   endtask

   task automatic test_lock();
      logic rv, ill, fl, ho, re;
      logic [31:0] rd;
      do_req(1'b1, 12'h3A0, 32'h0000_0089, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, fl, re, rd, cfg_lock[0], cfg_a[1:0], cfg_r[0]} !== {3'b111, 32'h89, 1'b1, 2'b01, 1'b1}) begin
         errors++;
         $display("FAIL lock_entry0: got rv/fl/rdy=%b%b%b rd=%h l=%b a=%b r=%b want 111 rd=00000089 l=1 a=01 r=1",
                  rv, fl, re, rd, cfg_lock[0], cfg_a[1:0], cfg_r[0]);
      end
      do_req(1'b1, 12'h3B0, 32'h0000_1234, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, fl, rd, addr[31:0]} !== {2'b10, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL addr0_locked: got rv/fl=%b%b rd=%h addr0=%h want 10 rd=0 addr0=0", rv, fl, rd, addr[31:0]);
      end
      do_req(1'b1, 12'h3B1, 32'h0000_0055, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd, addr[63:32]} !== {1'b1, 32'h55, 32'h55}) begin
         errors++;
         $display("FAIL addr1_write: got fl=%b rd=%h addr1=%h want 1 00000055 00000055", fl, rd, addr[63:32]);
      end
      do_req(1'b1, 12'h3A0, 32'h0088_0089, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd} !== {1'b1, 32'h0088_0089}) begin
         errors++;
         $display("FAIL lock_entry2_tor: got fl=%b rd=%h want 1 00880089", fl, rd);
      end
      do_req(1'b1, 12'h3B1, 32'h0000_0066, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd, addr[63:32]} !== {1'b0, 32'h55, 32'h55}) begin
         errors++;
         $display("FAIL addr1_tor_locked: got fl=%b rd=%h addr1=%h want 0 00000055 00000055", fl, rd, addr[63:32]);
      end
   endtask

   task automatic test_mml();
      logic rv, ill, fl, ho, re;
      logic [31:0] rd;
      apply_reset();
      do_req(1'b1, 12'h747, 32'h1, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd, mml} !== {1'b1, 32'h1, 1'b1}) begin
         errors++;
         $display("FAIL mml_set: got fl=%b rd=%h mml=%b want 1 00000001 1", fl, rd, mml);
      end
      do_req(1'b1, 12'h747, 32'h0, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd, mml} !== {1'b0, 32'h1, 1'b1}) begin
         errors++;
         $display("FAIL mml_sticky: got fl=%b rd=%h mml=%b want 0 00000001 1", fl, rd, mml);
      end
      do_req(1'b1, 12'h3A0, 32'h0000_8C00, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd, cfg_lock[1]} !== {1'b0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL mml_reject_9: got fl=%b rd=%h l1=%b want 0 00000000 0", fl, rd, cfg_lock[1]);
      end
      do_req(1'b1, 12'h3A0, 32'h0000_8F00, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd, cfg_lock[1], cfg_x[1]} !== {1'b1, 32'h8F00, 2'b11}) begin
         errors++;
         $display("FAIL mml_accept_15: got fl=%b rd=%h l1=%b x1=%b want 1 00008f00 1 1", fl, rd, cfg_lock[1], cfg_x[1]);
      end
      do_req(1'b1, 12'h3A0, 32'h0002_8F00, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd, cfg_w[2], cfg_r[2]} !== {1'b1, 32'h0002_8F00, 2'b10}) begin
         errors++;
         $display("FAIL mml_no_warl: got fl=%b rd=%h w2=%b r2=%b want 1 00028f00 1 0", fl, rd, cfg_w[2], cfg_r[2]);
      end
      do_req(1'b1, 12'h747, 32'h2, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd, mmwp} !== {1'b1, 32'h3, 1'b1}) begin
         errors++;
         $display("FAIL mmwp_set: got fl=%b rd=%h mmwp=%b want 1 00000003 1", fl, rd, mmwp);
      end
   endtask

   task automatic test_rlb();
      logic rv, ill, fl, ho, re;
      logic [31:0] rd;
      logic seen;
      apply_reset();
      do_req(1'b1, 12'h747, 32'h4, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd} !== {1'b1, 32'h4}) begin
         errors++;
         $display("FAIL rlb_set: got fl=%b rd=%h want 1 00000004", fl, rd);
      end
      do_req(1'b1, 12'h3A0, 32'h80, 0, rv, rd, ill, fl, ho, re);
      do_req(1'b1, 12'h3A0, 32'h81, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd, cfg_r[0]} !== {1'b1, 32'h81, 1'b1}) begin
         errors++;
         $display("FAIL rlb_bypass_lock: got fl=%b rd=%h r0=%b want 1 00000081 1", fl, rd, cfg_r[0]);
      end
      do_req(1'b1, 12'h747, 32'h0, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL rlb_clear: got fl=%b rd=%h want 1 00000000", fl, rd);
      end
      do_req(1'b1, 12'h747, 32'h4, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({fl, rd} !== {1'b0, 32'h0}) begin
         errors++;
         $display("FAIL rlb_frozen: got fl=%b rd=%h want 0 00000000", fl, rd);
      end
      // Reset while the flush of a pmpaddr5 write is outstanding.
      @(negedge clk);
      bus.csr_valid_i = 1'b1;
      bus.csr_write_i = 1'b1;
      bus.csr_addr_i  = 12'h3B5;
      bus.csr_wdata_i = 32'h0000_ABCD;
      @(negedge clk);
      bus.csr_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.pmp_flush_o, addr[191:160]} !== {1'b1, 32'h0000_ABCD}) begin
         errors++;
         $display("FAIL pre_reset_flush: got fl=%b addr5=%h want 1 0000abcd", bus.pmp_flush_o, addr[191:160]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.csr_ready_o, bus.csr_rvalid_o, bus.pmp_flush_o, bus.csr_illegal_o, cfg_lock, addr, mml, mmwp} !== {4'b1000, 266'h0}) begin
         errors++;
         $display("FAIL reset_in_flush: got rdy/rv/fl/ill=%b%b%b%b lock=%h addr5=%h want 1000 00 00000000",
                  bus.csr_ready_o, bus.csr_rvalid_o, bus.pmp_flush_o, bus.csr_illegal_o, cfg_lock, addr[191:160]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | bus.csr_rvalid_o | bus.pmp_flush_o | !bus.csr_ready_o;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_quiet: got activity=%b want 0", seen);
      end
      do_req(1'b0, 12'h747, 32'h0, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, fl, rd} !== {2'b10, 32'h0}) begin
         errors++;
         $display("FAIL post_reset_mseccfg: got rv/fl=%b%b rd=%h want 10 00000000", rv, fl, rd);
      end
   endtask

   task automatic test_illegal();
      logic rv, ill, fl, ho, re;
      logic [31:0] rd;
      do_req(1'b1, 12'h3C5, 32'hFFFF_FFFF, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, ill, fl, rd, addr} !== {3'b110, 32'h0, 256'h0}) begin
         errors++;
         $display("FAIL illegal_3c5: got rv/ill/fl=%b%b%b rd=%h want 110 00000000", rv, ill, fl, rd);
      end
      do_req(1'b1, 12'h3A4, 32'hFFFF_FFFF, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({ill, fl, cfg_lock} !== {2'b10, 8'h0}) begin
         errors++;
         $display("FAIL illegal_3a4: got ill/fl=%b%b lock=%h want 10 00", ill, fl, cfg_lock);
      end
      do_req(1'b1, 12'h757, 32'hFFFF_FFFF, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({ill, fl, rd, mml} !== {2'b00, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL mseccfgh: got ill/fl=%b%b rd=%h mml=%b want 00 00000000 0", ill, fl, rd, mml);
      end
      do_req(1'b1, 12'h3BC, 32'h1234_5678, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, ill, fl, rd} !== {3'b100, 32'h0}) begin
         errors++;
         $display("FAIL addr12_absent: got rv/ill/fl=%b%b%b rd=%h want 100 00000000", rv, ill, fl, rd);
      end
      do_req(1'b1, 12'h3A2, 32'h0F0F_0F0F, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({ill, fl, rd} !== {2'b00, 32'h0}) begin
         errors++;
         $display("FAIL cfg2_absent: got ill/fl=%b%b rd=%h want 00 00000000", ill, fl, rd);
      end
   endtask

   task automatic test_flush_hold();
      logic rv, ill, fl, ho, re;
      logic [31:0] rd;
      do_req(1'b1, 12'h3B3, 32'hDEAD_BEEF, 5, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, fl, ho, re, rd, addr[127:96]} !== {4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL flush_hold: got rv/fl/hold/rdy=%b%b%b%b rd=%h addr3=%h want 1111 deadbeef deadbeef",
                  rv, fl, ho, re, rd, addr[127:96]);
      end
   endtask

   task automatic test_back_to_back();
      logic rv, ill, fl, ho, re;
      logic [31:0] rd;
      do_req(1'b1, 12'h3B3, 32'hDEAD_BEEF, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, fl, re, rd} !== {3'b101, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL b2b_same_write: got rv/fl/rdy=%b%b%b rd=%h want 101 deadbeef", rv, fl, re, rd);
      end
      do_req(1'b0, 12'h3B3, 32'h0, 0, rv, rd, ill, fl, ho, re);
      checks++;
      if ({rv, fl, re, rd} !== {3'b101, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL b2b_read: got rv/fl/rdy=%b%b%b rd=%h want 101 deadbeef", rv, fl, re, rd);
      end
   endtask

   initial begin
      bus.csr_valid_i     = 1'b0;
      bus.csr_write_i     = 1'b0;
      bus.csr_addr_i      = '0;
      bus.csr_wdata_i     = '0;
      bus.pmp_flush_ack_i = 1'b0;
      test_reset();
      test_warl();
      test_lock();
      test_mml();
      test_rlb();
      test_illegal();
      test_flush_hold();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pmp_csr_file.md
# pmp_csr_file

Machine-mode CSR storage and write-arbitration block for the PMP/Smepmp unit. It holds pmpcfg, pmpaddr and mseccfg state and applies lock, WARL and Smepmp sticky-bit rules to each CSR write. It presents per-entry rule fields (lock, R, W, X, A, address) and mseccfg.MML/MMWP to the instruction- and data-side PMP rule checkers. Every write that changes state is followed by a flush handshake, so the fetch and LSU paths never match against stale rules.

## Interface
- ENABLE_SMEPMP, 1: implement mseccfg (MML, MMWP, RLB); when 0, mseccfg reads 0, writes are ignored, mml_o and mmwp_o are tied 0.
- PMP_ENTRIES, 8: number of entries; legal values are 4, 8, 12, 16.

Ports:
- cpu_clock_i  in  1  core clock; the only clock.
- cpu_reset_n_i  in  1  asynchronous, active-low reset.
- csr_valid_i  in  1  CSR request valid.
- csr_ready_o  out  1  block can accept a request; high only in IDLE.
- csr_write_i  in  1  1 = write, 0 = read.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  32  write data.
- csr_rvalid_o  out  1  one-cycle response strobe.
- csr_rdata_o  out  32  read data; post-write value for writes.
- csr_illegal_o  out  1  address not implemented; valid with csr_rvalid_o.
- pmp_flush_o  out  1  request to flush fetch and LSU PMP state.
- pmp_flush_ack_i  in  1  flush complete.
- cfg_lock_o, cfg_r_o, cfg_w_o, cfg_x_o  out  PMP_ENTRIES  per-entry bits.
- cfg_a_o  out  2*PMP_ENTRIES  address-matching mode; entry i occupies [2i+1:2i].
- addr_o  out  32*PMP_ENTRIES  pmpaddr[i] occupies [32i+31:32i].
- mml_o, mmwp_o  out  1  mseccfg bits.

## Operation
- Address map:
  - pmpcfg0..3 at 0x3A0–0x3A3, four 8-bit fields per register.
  - pmpaddr0..15 at 0x3B0–0x3BF.
  - mseccfg at 0x747; mseccfgh at 0x757 reads 0 and ignores writes.
- Entries at or above PMP_ENTRIES read 0 and ignore writes; they are not illegal.
- Any other address sets csr_illegal_o and changes no state.
- pmpcfg field layout: [7] L, [4:3] A, [2] X, [1] W, [0] R. Bits [6:5] read 0.
- Each field in a pmpcfg write is judged independently:
  - Locked entry (L=1) with RLB=0: field write is ignored.
  - WARL: when MML=0, R=0 with W=1 is stored as R=0, W=0.
  - MML=1 and RLB=0: a new value whose {L,R,W,X} code is 9, 10, 11 or 13 (an M-mode-executable region) is ignored. Code 15 is accepted.
- pmpaddr[i] write is ignored when:
  - entry i is locked and RLB=0, or
  - entry i+1 is locked, its A=TOR, and RLB=0.
- mseccfg layout: [0] MML, [1] MMWP, [2] RLB.
  - MML and MMWP are sticky-set: writing 1 sets them, writing 0 has no effect, and only reset clears them.
  - RLB can be written only while no entry is locked or RLB is already 1. Once RLB reads 0 with any entry locked, it stays 0 until reset.
- A write "changes state" if any stored bit differs after the rules are applied.

State machine:
- IDLE: csr_ready_o=1. On csr_valid_i, latch the request, commit it, and go to RESP.
- RESP: csr_rvalid_o=1. Go to FLUSH if the request was a state-changing write, otherwise to IDLE.
- FLUSH: pmp_flush_o=1 and csr_ready_o=0. On pmp_flush_ack_i, go to IDLE.

## Timing
- Reset values: all cfg, addr and mseccfg bits are 0.
  - csr_ready_o=1 (IDLE); csr_rvalid_o=0, csr_rdata_o=0, csr_illegal_o=0, pmp_flush_o=0.
- Request accepted in cycle T. Response (rdata, illegal) is registered and valid in T+1 only.
- Rule outputs reflect a write from T+1 onward, so they are already updated while pmp_flush_o is asserted.
- pmp_flush_o first rises in T+2. If ack is high in that same cycle, IDLE is reached at T+3. Minimum write-with-change occupancy is 3 cycles.
- pmp_flush_ack_i outside FLUSH is ignored.
- csr_valid_i outside IDLE is not accepted; the initiator holds the request.
- Reset asserted mid-FLUSH returns the block to IDLE and clears all state. No response or flush is issued afterwards.
- Reads of pmpcfg return the stored fields. Reads of pmpaddr return all 32 bits (G=0).

## Structure
- pmp_pkg holds:
  - CSR address constants.
  - A-field encodings: OFF=0, TOR=1, NA4=2, NAPOT=3.
  - a packed pmp_cfg_t struct {l, a, x, w, r}.
  - the Smepmp rejected-code list.
- Sub-module pmp_cfg_entry (one per entry):
  - holds the 8-bit cfg register and applies the lock, WARL and MML-reject rules to the incoming byte.
  - takes inputs rlb, mml, wr_en, wdata.
  - outputs the stored cfg and a changed flag.
- pmp_csr_file itself contains the address decode, the pmpaddr array, mseccfg, and the FSM.

## Test plan
- Reset, read pmpcfg0 -> rdata=0x0 at T+1; no flush.
- Write pmpcfg0=0x0000_0002 (entry0 W=1, R=0) with MML=0 -> stored 0x00; no change, so no flush.
- Write pmpcfg0=0x0000_0089 (L, A=TOR, R) -> flush at T+2. Then write pmpaddr0=0x1234 -> ignored, no flush; rdata=0.
- Write mseccfg=0x1 -> MML=1. Write mseccfg=0x0 -> MML stays 1. Write pmpcfg0 entry1 code 9 (0x8C00) -> rejected. Write code 15 -> accepted.
- Set RLB=1, lock entry0, clear RLB -> RLB=0. Write RLB=1 -> still 0. Then assert reset during FLUSH -> all outputs 0 and ready=1.
- Write to 0x3C5 -> csr_illegal_o=1, no state change. Hold ack low for 5 cycles during FLUSH -> csr_ready_o=0 throughout.
